regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
Parametrised 2-read/1-write register file with write-to-read bypass and a per-register pending-write scoreboard, for the pipelined CPU.
- Issue stage reserves the destination register.
- Writeback releases it.
- Decode reads operands plus per-operand busy flags to drive stall/forward logic.
- Register 0 is hardwired to zero.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W (index 0 is constant zero)
CNT_W, 2, pending-write counter width per register; max outstanding writes per register = 2**CNT_W-1
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = reads see stored contents only

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
rd_addr1  in  ADDR_W  read port 1 index
rd_data1  out  DATA_W  read port 1 data (combinational)
rd_busy1  out  1  read port 1 register has pending write (combinational)
rd_addr2  in  ADDR_W  read port 2 index
rd_data2  out  DATA_W  read port 2 data
rd_busy2  out  1  read port 2 pending flag
wr_en  in  1  writeback strobe; also releases one reservation
wr_addr  in  ADDR_W  writeback index
wr_data  in  DATA_W  writeback data
rsv_en  in  1  reservation request from issue
rsv_addr  in  ADDR_W  register to reserve
rsv_grant  out  1  reservation accepted this cycle (combinational)

Interface: reset reset, asynchronous, active-high; clock clk.

Behaviour:
- Reset (async, immediate):
  - All data registers 1..depth-1 = 0.
  - All pending counters = 0.
  - Hence rd_data* = 0 and rd_busy* = 0 while reset is high.
- Write:
  - At posedge, if wr_en && wr_addr != 0, mem[wr_addr] <= wr_data.
  - Writes to index 0 are ignored entirely, including counter release.
- Read, combinational:
  - rd_addrN == 0 -> rd_dataN = 0.
  - Else if BYPASS && wr_en && wr_addr == rd_addrN -> rd_dataN = wr_data.
  - Else rd_dataN = mem[rd_addrN].
- Counter update per register r != 0, at posedge:
  - inc = rsv_en && rsv_grant && rsv_addr == r
  - dec = wr_en && wr_addr == r && cnt[r] != 0
  - cnt[r] <= cnt[r] + inc - dec.
  - inc and dec in the same cycle -> unchanged.
  - A write to a register with cnt = 0 is legal: data updated, counter stays 0, no underflow.
- rsv_grant:
  - 1 if rsv_addr == 0.
  - 0 if cnt[rsv_addr] == max and no same-cycle release to that register.
  - Otherwise 1.
  - A denied request leaves all state unchanged; issue must retry.
  - rsv_grant is don't-care when rsv_en = 0, but computed identically.
- rd_busyN:
  - rd_addrN == 0 -> 0.
  - Else busy = cnt[rd_addrN] != 0.
  - Exception with BYPASS = 1: if this cycle's writeback to that register brings cnt from 1 to 0 (wr_en, no same-cycle reserve of it), busy = 0 because the data is forwarded.
  - A same-cycle reservation does not raise busy until the next cycle.
- Latency:
  - Write visible at read ports next cycle, or same cycle when BYPASS = 1.
  - Scoreboard state visible next cycle.
- Reset asserted mid-operation: all pending reservations are discarded; in-flight writebacks after reset deassertion write data normally with cnt = 0 (no underflow).

Decomposition:
- Shared package regfile_pkg: DATA_W/ADDR_W/CNT_W defaults and the ZERO_REG index constant.
- One natural sub-module, rf_scoreboard: counter array, grant and busy logic. It takes the rsv/wr/rd address ports and emits rsv_grant and the raw busy flags.
- Top level holds the data array and the bypass muxes.

Test Plan:
- Reset then read all 32 indices -> every rd_data = 0, rd_busy = 0; write 0xDEADBEEF to r0 -> r0 still reads 0.
- Write r5 = 0x12345678 with rd_addr1 = 5 in the same cycle, BYPASS = 1 -> rd_data1 = 0x12345678 that cycle. With BYPASS = 0 -> old value 0 that cycle, new value the next cycle.
- Reserve r7 -> next cycle rd_busy2 (rd_addr2 = 7) = 1. Writeback r7 = 0xA5 -> same cycle busy = 0 and data 0xA5 (BYPASS = 1); next cycle cnt = 0.
- CNT_W = 2: reserve r3 three times -> all granted. Fourth -> rsv_grant = 0, cnt stays 3. Fourth reserve in the same cycle as a writeback to r3 -> granted, cnt stays 3.
- Simultaneous reserve and writeback of r9 with cnt = 1 -> cnt stays 1, rd_busy = 1 next cycle. Writeback to r10 with cnt = 0 -> data written, cnt stays 0.
- Reserve r4 twice, assert reset mid-cycle asynchronously -> busy drops immediately, r4 = 0. After release, write r4 = 0x55 -> reads 0x55, busy 0.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults for the register file / scoreboard slice:
//               data, index and pending-counter widths, plus the index of the
//               hardwired zero register.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 2;

  // Register index that always reads as zero and is never reserved.
  localparam int ZERO_REG   = 0;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Per-register pending-write counters. Issue reserves a
//               destination (increment), writeback releases it (decrement).
//               Produces the reservation grant and raw busy flags for two
//               read ports, plus a per-port "last release" flag that lets the
//               top level clear busy when the final pending write is being
//               forwarded in the same cycle.
// Ports       : clk, reset      - clock, asynchronous active-high reset
//               rsv_en/rsv_addr - reservation request from issue
//               rsv_grant       - reservation accepted (combinational)
//               wr_en/wr_addr   - writeback strobe / index (releases one)
//               rd_addr1/2      - read port indices
//               raw_busy1/2     - pending counter of that register is nonzero
//               last_rel1/2     - this cycle's writeback drains it from 1 to 0
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_grant,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              raw_busy1,
  output logic              raw_busy2,
  output logic              last_rel1,
  output logic              last_rel2
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [CNT_W-1:0]  c_cnt_max  = '1;
  localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] c_zero_reg = ADDR_W'(ZERO_REG);

  logic [CNT_W-1:0] r_cnt     [DEPTH];
  logic [CNT_W-1:0] w_cnt_nxt [DEPTH];

  logic w_rsv_release;
  logic w_inc_ok;
  logic w_dec_ok;

  // A full counter can still take a reservation when the same register is
  // being released this cycle: the net count does not change.
  always_comb begin
    w_rsv_release = wr_en && (wr_addr == rsv_addr) && (r_cnt[rsv_addr] != '0);
    rsv_grant     = (rsv_addr == c_zero_reg) ||
                    (r_cnt[rsv_addr] != c_cnt_max) ||
                    w_rsv_release;
    // Zero register never counts; a writeback to an idle register is legal
    // and must not underflow.
    w_inc_ok      = rsv_en && rsv_grant && (rsv_addr != c_zero_reg);
    w_dec_ok      = wr_en && (wr_addr != c_zero_reg) && (r_cnt[wr_addr] != '0);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_inc_ok && (rsv_addr == ADDR_W'(i)) &&
          !(w_dec_ok && (wr_addr == ADDR_W'(i)))) begin
        w_cnt_nxt[i] = r_cnt[i] + c_cnt_one;
      end else if (w_dec_ok && (wr_addr == ADDR_W'(i)) &&
                   !(w_inc_ok && (rsv_addr == ADDR_W'(i)))) begin
        w_cnt_nxt[i] = r_cnt[i] - c_cnt_one;
      end
    end
    w_cnt_nxt[ZERO_REG] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Busy reflects registered state only; a reservation made this cycle shows
  // up one cycle later.
  always_comb begin
    raw_busy1 = (rd_addr1 != c_zero_reg) && (r_cnt[rd_addr1] != '0);
    raw_busy2 = (rd_addr2 != c_zero_reg) && (r_cnt[rd_addr2] != '0);
    last_rel1 = wr_en && (rd_addr1 != c_zero_reg) && (wr_addr == rd_addr1) &&
                (r_cnt[rd_addr1] == c_cnt_one) &&
                !(rsv_en && rsv_grant && (rsv_addr == rd_addr1));
    last_rel2 = wr_en && (rd_addr2 != c_zero_reg) && (wr_addr == rd_addr2) &&
                (r_cnt[rd_addr2] == c_cnt_one) &&
                !(rsv_en && rsv_grant && (rsv_addr == rd_addr2));
  end

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : 2-read / 1-write register file with optional write-to-read
//               bypass and a per-register pending-write scoreboard. Register 0
//               reads as zero and ignores writes and reservations.
// Ports       : clk, reset          - clock, asynchronous active-high reset
//               rd_addr1/2          - read indices
//               rd_data1/2          - read data (combinational)
//               rd_busy1/2          - pending-write flag (combinational)
//               wr_en/wr_addr/wr_data - writeback; also releases one pending
//               rsv_en/rsv_addr     - reservation request from issue
//               rsv_grant           - reservation accepted (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_busy1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_grant
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] c_zero_reg = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_raw_busy1;
  logic w_raw_busy2;
  logic w_last_rel1;
  logic w_last_rel2;
  logic w_fwd1;
  logic w_fwd2;

  // --------------------------------------------------------------------------
  // Data array
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr_en && (wr_addr != c_zero_reg)) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .rsv_grant (rsv_grant),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .raw_busy1 (w_raw_busy1),
    .raw_busy2 (w_raw_busy2),
    .last_rel1 (w_last_rel1),
    .last_rel2 (w_last_rel2)
  );

  // --------------------------------------------------------------------------
  // Bypass select. Forwarding is suppressed while reset is asserted so the
  // read ports hold zero for the whole reset window.
  // --------------------------------------------------------------------------
  generate
    if (BYPASS != 0) begin : g_bypass
      assign w_fwd1 = !reset && wr_en && (wr_addr == rd_addr1);
      assign w_fwd2 = !reset && wr_en && (wr_addr == rd_addr2);
    end else begin : g_no_bypass
      assign w_fwd1 = 1'b0;
      assign w_fwd2 = 1'b0;
    end
  endgenerate

  always_comb begin
    rd_data1 = '0;
    if (rd_addr1 != c_zero_reg) begin
      rd_data1 = w_fwd1 ? wr_data : r_mem[rd_addr1];
    end
    rd_data2 = '0;
    if (rd_addr2 != c_zero_reg) begin
      rd_data2 = w_fwd2 ? wr_data : r_mem[rd_addr2];
    end
  end

  // When the final pending write is forwarded this cycle the operand is
  // already usable, so the consumer need not stall. Without bypass the data
  // only lands next cycle, so busy stays up until the counter drains.
  always_comb begin
    rd_busy1 = w_raw_busy1 && !(w_fwd1 && w_last_rel1);
    rd_busy2 = w_raw_busy2 && !(w_fwd2 && w_last_rel2);
  end

endmodule : regfile_scoreboard
`default_nettype wire
